// File: rtl/frame_sched_if.sv
// frame_sched_if: tick input, voice/filter handshakes and status outputs of the frame scheduler
interface frame_sched_if;
    logic        tick_i;
    logic        start_o;
    logic [1:0]  voice_idx_o;
    logic        done_i;
    logic        filt_start_o;
    logic        filt_done_i;
    logic        sample_valid_o;
    logic        busy_o;
    logic        overrun_o;
    logic [7:0]  overrun_cnt_o;
    logic        fault_o;
    logic [15:0] frame_cnt_o;

    modport master (
        input  tick_i, done_i, filt_done_i,
        output start_o, voice_idx_o, filt_start_o, sample_valid_o, busy_o,
               overrun_o, overrun_cnt_o, fault_o, frame_cnt_o
    );

    modport slave (
        output tick_i, done_i, filt_done_i,
        input  start_o, voice_idx_o, filt_start_o, sample_valid_o, busy_o,
               overrun_o, overrun_cnt_o, fault_o, frame_cnt_o
    );
endinterface

// File: rtl/frame_sched.sv
// frame_sched: per-tick frame sequencer (voices, filter, sample strobe) with overrun and timeout tracking
module frame_sched #(
    parameter int NUM_VOICES = 3,
    parameter int TIMEOUT    = 255
) (
    input logic           clk_i,
    input logic           rst_i,
    frame_sched_if.master bus
);
    typedef enum logic [2:0] {IDLE, VSTART, VWAIT, FSTART, FWAIT, OUT} state_t;

    localparam logic [1:0] LAST_VOICE = 2'(NUM_VOICES - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] tmr;
    logic       timed_out;
    logic       dropped;

    assign timed_out  = tmr == TMO_LAST;
    assign dropped    = bus.tick_i && state != IDLE;
    assign bus.busy_o = state != IDLE;

    // Frame sequencing, registered pulses and status counters; a dropped tick never disturbs the frame
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state              <= IDLE;
            tmr                <= '0;
            bus.start_o        <= 1'b0;
            bus.voice_idx_o    <= '0;
            bus.filt_start_o   <= 1'b0;
            bus.sample_valid_o <= 1'b0;
            bus.overrun_o      <= 1'b0;
            bus.overrun_cnt_o  <= '0;
            bus.fault_o        <= 1'b0;
            bus.frame_cnt_o    <= '0;
        end else begin
            bus.start_o        <= 1'b0;
            bus.filt_start_o   <= 1'b0;
            bus.sample_valid_o <= 1'b0;
            bus.overrun_o      <= dropped;
            if (dropped && bus.overrun_cnt_o != 8'hFF)
                bus.overrun_cnt_o <= bus.overrun_cnt_o + 8'd1;
            case (state)
                IDLE: if (bus.tick_i) begin
                    bus.voice_idx_o <= '0;
                    bus.start_o     <= 1'b1;
                    state           <= VSTART;
                end
                VSTART: begin
                    tmr   <= '0;
                    state <= VWAIT;
                end
                VWAIT: if (bus.done_i || timed_out) begin
                    if (!bus.done_i)
                        bus.fault_o <= 1'b1;
                    if (bus.voice_idx_o == LAST_VOICE) begin
                        bus.filt_start_o <= 1'b1;
                        state            <= FSTART;
                    end else begin
                        bus.voice_idx_o <= bus.voice_idx_o + 2'd1;
                        bus.start_o     <= 1'b1;
                        state           <= VSTART;
                    end
                end else begin
                    tmr <= tmr + 8'd1;
                end
                FSTART: begin
                    tmr   <= '0;
                    state <= FWAIT;
                end
                FWAIT: if (bus.filt_done_i || timed_out) begin
                    if (!bus.filt_done_i)
                        bus.fault_o <= 1'b1;
                    bus.sample_valid_o <= 1'b1;
                    bus.frame_cnt_o    <= bus.frame_cnt_o + 16'd1;
                    state              <= OUT;
                end else begin
                    tmr <= tmr + 8'd1;
                end
                OUT:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/frame_sched.md
# frame_sched

Per-sample frame scheduler driven by the 50 kHz tick pulse. On each accepted tick it sequences one synthesis frame: starts each voice engine in turn through a start/done handshake, then starts the filter stage, then emits a one-cycle sample-valid strobe to the output stage. It sits between the tick generator and the voice/filter datapath, and detects and counts ticks that arrive while a frame is still in progress.

## Interface
Parameters:
- NUM_VOICES, 3: voices sequenced per frame, legal range 1..4.
- TIMEOUT, 255: maximum cycles spent waiting in any one done handshake, legal range 2..255.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- tick_i  in  1  one-cycle sample tick, 50 kHz.
- start_o  out  1  one-cycle voice start pulse.
- voice_idx_o  out  2  index of the voice being started or awaited.
- done_i  in  1  voice completion pulse.
- filt_start_o  out  1  one-cycle filter start pulse.
- filt_done_i  in  1  filter completion pulse.
- sample_valid_o  out  1  one-cycle strobe that marks the frame as complete.
- busy_o  out  1  high in every state except IDLE.
- overrun_o  out  1  one-cycle pulse for each dropped tick.
- overrun_cnt_o  out  8  dropped-tick count, saturates at 255.
- fault_o  out  1  sticky flag set on any handshake timeout.
- frame_cnt_o  out  16  count of completed frames, wraps 65535 to 0.

## Operation
- Reset (rst_i high at a clock edge): state=IDLE, voice_idx_o=0, all pulses 0, busy_o=0, overrun_cnt_o=0, fault_o=0, frame_cnt_o=0, timeout counter 0. Reset takes priority over every other input.
- The FSM has six states: IDLE, VSTART, VWAIT, FSTART, FWAIT, OUT. All outputs are decoded from registers only; no input reaches an output combinationally.
- IDLE: when tick_i=1, set voice_idx=0 and go to VSTART.
- VSTART: start_o=1 for this one cycle, clear the timeout counter, go to VWAIT.
- VWAIT: exit when done_i=1 or the timeout counter equals TIMEOUT-1.
  - If the exit is a timeout, set fault_o.
  - If voice_idx=NUM_VOICES-1, go to FSTART.
  - Otherwise increment voice_idx and go to VSTART.
  - Otherwise, stay and increment the timeout counter.
- FSTART: filt_start_o=1 for one cycle, clear the timeout counter, go to FWAIT.
- FWAIT: exit on filt_done_i=1 or timeout, with the same rule as VWAIT; on exit go to OUT.
- OUT: sample_valid_o=1 for one cycle, frame_cnt_o increments by 1 (modulo 2^16), go to IDLE.
- voice_idx_o holds its value through FSTART, FWAIT and OUT, and returns to 0 on the next accepted tick.
- Handshake inputs:
  - done_i is ignored outside VWAIT, including the VSTART cycle.
  - filt_done_i is ignored outside FWAIT.
  - A stray done_i is never counted or stored.
- Overrun: tick_i=1 in any state other than IDLE, including OUT, drops that tick.
  - overrun_o pulses on the next cycle.
  - overrun_cnt_o increments, holding at 255 once saturated.
  - The frame in progress is unaffected; ticks are never queued.
- fault_o clears only on reset. A timeout still advances the sequence, so the frame always completes.

## Timing
- Tick sampled at edge T: VSTART with start_o=1 in cycle T+1; VWAIT begins at T+2.
- Minimum frame, with each done arriving in the first wait cycle: 2 cycles per voice, then FSTART, FWAIT, OUT.
  - With NUM_VOICES=3: start_o in T+1, T+3, T+5; filt_start_o in T+7; sample_valid_o in T+9; busy_o high T+1..T+9; IDLE again at T+10.
- A tick at T+10 is accepted. A tick in any of T+1..T+9 is an overrun.
- Worst-case frame is (NUM_VOICES+1)·(TIMEOUT+1)+1 cycles, which must be ≤ 999 at the default configuration (4·256+1=1025 exceeds it; integration keeps TIMEOUT ≤ 248 when NUM_VOICES=3).
- Reset asserted mid-frame: the next cycle is IDLE with every output at its reset value; no start_o, filt_start_o or sample_valid_o pulse is emitted from the aborted frame.

## Test plan
- Nominal frame: reset, tick at T, done_i one cycle after each start_o, filt_done_i the same way -> start_o at T+1/T+3/T+5 with voice_idx_o 0/1/2, filt_start_o at T+7, sample_valid_o at T+9, frame_cnt_o=1, fault_o=0.
- Overrun: tick at T and again at T+4 -> overrun_o pulse at T+5, overrun_cnt_o=1, frame finishes as in the nominal case; 300 overrun ticks -> overrun_cnt_o=255.
- Timeout: voice 1 never asserts done_i, TIMEOUT=8 -> 8 cycles in VWAIT, voice 2 start follows, fault_o=1 and stays 1, sample_valid_o still asserted, frame_cnt_o increments.
- Stray handshakes: done_i during IDLE, during VSTART and during FWAIT; filt_done_i during VWAIT -> all ignored, frame timing matches the nominal case.
- Reset mid-frame: rst_i asserted in VWAIT of voice 1 -> next cycle all outputs at reset values; a following tick produces a clean frame with frame_cnt_o=1.
- Wrap and boundaries: preload 65535 completed frames, or run NUM_VOICES=1 -> frame_cnt_o wraps to 0; a single voice gives sample_valid_o at T+5; a tick coincident with rst_i is not accepted.
